// File: rtl/isqrt_pkg.sv
// Shared constants and the per-stage state type for the pipelined integer square root.
package isqrt_pkg;

    localparam int ISQRT_N_BITS = 32;
    localparam int ISQRT_Y_BITS = ISQRT_N_BITS / 2;
    localparam int ISQRT_LAT    = ISQRT_Y_BITS;

    // State carried from one root-bit iteration to the next at the default width.
    typedef struct packed {
        logic [ISQRT_Y_BITS+1:0] rem;
        logic [ISQRT_Y_BITS-1:0] root;
        logic [ISQRT_N_BITS-1:0] xs;
    } isqrt_state_t;

endpackage

// File: rtl/isqrt_stage.sv
// One restoring square-root iteration: decides one root bit, then registers the result.
// Data registers are clock-enabled by the incoming valid and carry no reset. The exception
// is the root register of the final stage, which drives the block output and clears on reset.
module isqrt_stage
    import isqrt_pkg::*;
#(
    parameter int N_BITS = ISQRT_N_BITS,
    parameter bit LAST   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [N_BITS/2+1:0]   in_rem,
    input  logic [N_BITS/2-1:0]   in_root,
    input  logic [N_BITS-1:0]     in_xs,
    output logic                  out_vld,
    output logic [N_BITS/2+1:0]   out_rem,
    output logic [N_BITS/2-1:0]   out_root,
    output logic [N_BITS-1:0]     out_xs
);

    localparam int Y = N_BITS / 2;

    logic [Y+1:0]      r_shift;
    logic [Y+1:0]      t_trial;
    logic [Y+1:0]      rem_nxt;
    logic [Y-1:0]      root_nxt;
    logic [N_BITS-1:0] xs_nxt;
    logic              fits;
    logic              unused_bits;

    // Before the last iteration rem < 2^Y and root < 2^(Y-1), so these top bits are
    // always zero and dropping them on the shifts loses nothing.
    assign unused_bits = ^{in_rem[Y+1:Y], in_root[Y-1]};

    assign r_shift = {in_rem[Y-1:0], in_xs[N_BITS-1 -: 2]};
    assign t_trial = {in_root, 2'b01};

    // Trial subtraction: keep the difference and set the root bit when the trial fits.
    always_comb begin
        fits     = (r_shift >= t_trial);
        rem_nxt  = fits ? (r_shift - t_trial) : r_shift;
        root_nxt = {in_root[Y-2:0], fits};
        xs_nxt   = {in_xs[N_BITS-3:0], 2'b00};
    end

    // Valid bit of this stage; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_vld <= 1'b0;
        else     out_vld <= in_vld;
    end

    // Remainder and remaining argument bits load only when a real request passes.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            out_rem <= rem_nxt;
            out_xs  <= xs_nxt;
        end
    end

    generate
        if (LAST) begin : g_root_rst
            // Final root is the visible result: cleared on reset, held between results.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         out_root <= '0;
                else if (in_vld) out_root <= root_nxt;
            end
        end else begin : g_root
            // Intermediate root bits, enabled by the incoming valid.
            always_ff @(posedge clk) begin
                if (in_vld) out_root <= root_nxt;
            end
        end
    endgenerate

endmodule

// File: rtl/isqrt_pipe.sv
// Fully pipelined floor(sqrt(x)): one root bit per stage, one argument per clock,
// fixed latency of N_BITS/2 cycles, results in issue order. N_BITS must be even and >= 4.
module isqrt_pipe
    import isqrt_pkg::*;
#(
    parameter int N_BITS = ISQRT_N_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  x_vld,
    input  logic [N_BITS-1:0]     x,
    output logic                  y_vld,
    output logic [N_BITS/2-1:0]   y
);

    localparam int Y   = N_BITS / 2;
    localparam int LAT = Y;

    // Index k holds the inputs of stage k; index LAT holds the outputs of the last stage.
    logic              vld_s  [0:LAT];
    logic [Y+1:0]      rem_s  [0:LAT];
    logic [Y-1:0]      root_s [0:LAT];
    logic [N_BITS-1:0] xs_s   [0:LAT];
    logic              unused_tail;

    assign vld_s[0]  = x_vld;
    assign rem_s[0]  = '0;
    assign root_s[0] = '0;
    assign xs_s[0]   = x;

    // The valid shift chain runs through the stages alongside the data, so a gap in
    // x_vld reappears as the same gap in y_vld.
    genvar g;
    generate
        for (g = 0; g < LAT; g++) begin : g_stage
            isqrt_stage #(
                .N_BITS (N_BITS),
                .LAST   (g == LAT - 1)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .in_vld   (vld_s[g]),
                .in_rem   (rem_s[g]),
                .in_root  (root_s[g]),
                .in_xs    (xs_s[g]),
                .out_vld  (vld_s[g+1]),
                .out_rem  (rem_s[g+1]),
                .out_root (root_s[g+1]),
                .out_xs   (xs_s[g+1])
            );
        end
    endgenerate

    // The final remainder is dropped (no rounding) and the argument is fully consumed.
    assign unused_tail = ^{rem_s[LAT], xs_s[LAT]};

    assign y_vld = vld_s[LAT];
    assign y     = root_s[LAT];

endmodule

// File: tb/tb_isqrt_pipe.sv
// Directed and table-driven bench for isqrt_pipe (N_BITS=32, latency 16).
module tb_isqrt_pipe;

    localparam int LAT = 16;

    logic        clk;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;

    typedef struct {
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        logic [15:0] y;
    } exp_t;

    vec_t        vecs [10];
    exp_t        expQ [$];
    int unsigned cyc;
    logic [15:0] lastY;
    logic        checkEn;
    int          nChecks;
    int          nFails;

    isqrt_pipe #(.N_BITS(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (y_vld),
        .y     (y)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to timestamp when each result is due.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference root built bit by bit from squares, independent of the restoring method.
    function automatic logic [15:0] isqrtRef(input logic [31:0] v);
        logic [15:0]     r;
        logic [15:0]     c;
        longint unsigned c64;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            c   = r | (16'd1 << b);
            c64 = {48'd0, c};
            if (c64 * c64 <= {32'd0, v}) r = c;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Drives one cycle of input just after a rising edge and records when a result is due.
    task automatic applyStimulus(input logic v, input logic [31:0] val, input logic [15:0] expY);
        exp_t e;
        x_vld = v;
        x     = val;
        if (v) begin
            e.cyc = cyc + LAT;
            e.y   = expY;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drainPipe(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            applyStimulus(1'b0, 32'd0, 16'd0);
            n++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    // Every falling edge: a due result must be present with the right value; otherwise
    // y_vld must be low and y must hold the last result.
    always @(negedge clk) begin
        if (checkEn) begin
            if (expQ.size() != 0 && expQ[0].cyc == cyc) begin
                checkOutput("y_vld_pulse", {31'd0, y_vld}, 32'd1);
                checkOutput("y_value", {16'd0, y}, {16'd0, expQ[0].y});
                lastY = expQ[0].y;
                void'(expQ.pop_front());
            end else begin
                checkOutput("y_vld_idle", {31'd0, y_vld}, 32'd0);
                checkOutput("y_hold", {16'd0, y}, {16'd0, lastY});
            end
        end
    end

    initial begin
        logic [31:0] v;

        vecs[0] = '{32'd0,          16'd0};
        vecs[1] = '{32'd1,          16'd1};
        vecs[2] = '{32'd3,          16'd1};
        vecs[3] = '{32'd4,          16'd2};
        vecs[4] = '{32'd15,         16'd3};
        vecs[5] = '{32'd16,         16'd4};
        vecs[6] = '{32'hFFFF_FFFF,  16'hFFFF};
        vecs[7] = '{32'hFFFE_0001,  16'hFFFF};
        vecs[8] = '{32'hFFFE_0000,  16'hFFFE};
        vecs[9] = '{32'h4000_0000,  16'h8000};

        nChecks = 0;
        nFails  = 0;
        checkEn = 1'b0;
        lastY   = 16'd0;
        rst     = 1'b1;
        x_vld   = 1'b0;
        x       = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_y_vld", {31'd0, y_vld}, 32'd0);
        checkOutput("reset_y", {16'd0, y}, 32'd0);
        rst     = 1'b0;
        checkEn = 1'b1;

        $display("[TB] single requests and extremes");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].x, vecs[i].y);
            repeat (19) applyStimulus(1'b0, 32'd0, 16'd0);
        end
        drainPipe("drain_table");

        $display("[TB] back-to-back random");
        for (int i = 0; i < 1000; i++) begin
            v = $urandom;
            applyStimulus(1'b1, v, isqrtRef(v));
        end
        drainPipe("drain_b2b");

        $display("[TB] random bubbles");
        for (int i = 0; i < 500; i++) begin
            v = $urandom;
            if ($urandom_range(0, 1) == 1) applyStimulus(1'b1, v, isqrtRef(v));
            else                           applyStimulus(1'b0, v, 16'd0);
        end
        drainPipe("drain_bubbles");

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 18; i++) begin
            v = 32'd100 + 32'(i) * 32'd7919;
            applyStimulus(1'b1, v, isqrtRef(v));
        end
        x_vld = 1'b0;
        #2;
        checkOutput("pre_rst_y_vld", {31'd0, y_vld}, 32'd1);
        rst = 1'b1;
        expQ.delete();
        lastY = 16'd0;
        #1;
        checkOutput("rst_async_y_vld", {31'd0, y_vld}, 32'd0);
        checkOutput("rst_async_y", {16'd0, y}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) applyStimulus(1'b0, 32'd0, 16'd0);
        applyStimulus(1'b1, 32'd81, 16'd9);
        drainPipe("drain_after_rst");

        $display("[TB] idle with undriven argument");
        lastY = 16'd9;
        repeat (40) applyStimulus(1'b0, 32'bx, 16'd0);
        checkOutput("idle_x_y", {16'd0, y}, 32'd9);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
